// File: rtl/uram_pkg.sv
// Shared URAM line constants and the sequencer state encoding.
// No logic; compile-time only.
// Imported by the line writer, its packer and the read-side sequencer.
package uram_pkg;

  localparam int URAM_WIDTH  = 3072;
  localparam int URAM_ADDR_W = 12;
  localparam int URAM_BEAT_W = 64;
  localparam int URAM_BEATS  = URAM_WIDTH / URAM_BEAT_W;

  // Sequencer states, shared with the read side.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } uram_state_t;

  // Beat index width; a one-beat line still needs a 1-bit index.
  function automatic int idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/uram_line_packer.sv
// Line assembly register: drops each loaded beat into the slot named by the beat index.
// Latency: a beat presented with load is in line after the next rising edge.
// Backpressure: none internally; the caller only asserts load on an accepted beat.
module uram_line_packer
  import uram_pkg::*;
#(
  parameter int WIDTH  = URAM_WIDTH,
  parameter int BEAT_W = URAM_BEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [BEAT_W-1:0] beat,
  output logic [WIDTH-1:0]  line,
  output logic              last
);

  localparam int BEATS = WIDTH / BEAT_W;
  localparam int IDX_W = idx_width(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_line;

  assign line = r_line;
  assign last = (r_idx == LAST_IDX);

  // Store the beat in its slot and advance the index, wrapping after the final slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_line <= '0;
    end else if (clr) begin
      r_idx <= '0;
    end else if (load) begin
      r_line[r_idx*BEAT_W +: BEAT_W] <= beat;
      r_idx <= last ? '0 : r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/uram_line_writer.sv
// Packs narrow input beats into URAM lines and writes each line to consecutive addresses.
// Latency: write strobe the cycle after the last beat of a line is accepted; BEATS+1 cycles per line.
// Backpressure: s_ready low in IDLE and during the one-cycle WRITE bubble; the source holds its beat.
module uram_line_writer
  import uram_pkg::*;
#(
  parameter int WIDTH     = URAM_WIDTH,
  parameter int URAM_ADDR = URAM_ADDR_W,
  parameter int BEAT_W    = URAM_BEAT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [URAM_ADDR-1:0] start_addr,
  input  logic [URAM_ADDR:0]   num_lines,
  input  logic                 s_valid,
  input  logic [BEAT_W-1:0]    s_data,
  output logic                 s_ready,
  output logic                 wr_uram,
  output logic [URAM_ADDR-1:0] wr_addr,
  output logic [WIDTH-1:0]     wr_data,
  output logic                 busy,
  output logic                 done
);

  localparam logic [URAM_ADDR:0] REM_ONE = (URAM_ADDR+1)'(1);

  uram_state_t          r_state;
  logic [URAM_ADDR-1:0] r_addr;
  logic [URAM_ADDR:0]   r_remaining;
  logic                 r_s_ready;
  logic                 r_wr_uram;
  logic [URAM_ADDR-1:0] r_wr_addr;
  logic [WIDTH-1:0]     r_wr_data;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_clr;
  logic                 w_load;
  logic                 w_last;
  logic [WIDTH-1:0]     w_line;
  logic [WIDTH-1:0]     w_line_full;

  assign w_clr  = (r_state == IDLE) && start;
  assign w_load = (r_state == FILL) && s_valid;

  uram_line_packer #(
    .WIDTH  (WIDTH),
    .BEAT_W (BEAT_W)
  ) u_packer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .load  (w_load),
    .beat  (s_data),
    .line  (w_line),
    .last  (w_last)
  );

  // The final beat is still on s_data when the line is captured, so merge it into the top slot.
  always_comb begin
    w_line_full = w_line;
    w_line_full[WIDTH-1 -: BEAT_W] = s_data;
  end

  // Job sequencer: accept a job, fill lines beat by beat, emit one write per line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_s_ready   <= 1'b0;
      r_wr_uram   <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done    <= 1'b0;
          r_wr_uram <= 1'b0;
          if (start) begin
            r_addr      <= start_addr;
            r_remaining <= num_lines;
            if (num_lines != '0) begin
              r_state   <= FILL;
              r_s_ready <= 1'b1;
              r_busy    <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        FILL: begin
          if (s_valid && w_last) begin
            r_state   <= WRITE;
            r_s_ready <= 1'b0;
            r_wr_uram <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= w_line_full;
            r_done    <= (r_remaining == REM_ONE);
          end
        end
        WRITE: begin
          r_wr_uram   <= 1'b0;
          r_done      <= 1'b0;
          r_addr      <= r_addr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
          if (r_remaining == REM_ONE) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state   <= FILL;
            r_s_ready <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_s_ready <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = r_s_ready;
  assign wr_uram = r_wr_uram;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: doc/uram_line_writer.md
# uram_line_writer

Write-side companion to the URAM line read model. Accepts a stream of narrow beats over valid/ready, packs `WIDTH/BEAT_W` beats into one `WIDTH`-bit line, and issues one single-cycle URAM write per completed line at consecutive addresses. Sits between the host/DMA load path and the URAM array, and fills the lines that the read side later fetches with `rd_uram`/`rd_addr`.

## Interface
- `WIDTH`, 3072, URAM line width in bits.
- `URAM_ADDR`, 12, URAM address width.
- `BEAT_W`, 64, input beat width; `WIDTH % BEAT_W == 0` is required. `BEATS = WIDTH/BEAT_W` (48 at defaults).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle job request; sampled only in IDLE.
- `start_addr`  in  URAM_ADDR  first line address of the job.
- `num_lines`  in  URAM_ADDR+1  lines in the job; 0 to 2^URAM_ADDR.
- `s_valid`  in  1  input beat valid.
- `s_data`  in  BEAT_W  input beat.
- `s_ready`  out  1  beat accepted when `s_valid && s_ready`.
- `wr_uram`  out  1  one-cycle URAM write strobe.
- `wr_addr`  out  URAM_ADDR  write address; valid while `wr_uram` is high.
- `wr_data`  out  WIDTH  packed line; valid while `wr_uram` is high.
- `busy`  out  1  high in FILL and WRITE.
- `done`  out  1  one-cycle job-complete pulse.

## Operation
- States: IDLE, FILL, WRITE.
- IDLE: `s_ready=0`. On `start`, latch `start_addr` into the address register and `num_lines` into the remaining-line counter.
  - If `num_lines != 0`: go to FILL and clear the beat index.
  - If `num_lines == 0`: pulse `done` the next cycle and stay in IDLE.
- FILL: `s_ready=1`.
  - Beat k (k = 0..BEATS-1) is written to line bits `[k*BEAT_W +: BEAT_W]`. Beat 0 goes to the LSBs.
  - Index increments only on handshake. `s_valid` low stalls with no state change.
  - Accepting beat BEATS-1 moves to WRITE.
- WRITE (one cycle): `s_ready=0`, `wr_uram=1`, `wr_addr` = current address, `wr_data` = packed line.
  - Then address = address+1, wrapping mod 2^URAM_ADDR, and remaining = remaining-1.
  - If remaining was 1: `done=1` in this same cycle, next state IDLE.
  - Otherwise: next state FILL with beat index 0.
- `start` while `busy` is ignored. Job parameters never change mid-job.
- Beats offered while `s_ready=0` are not consumed. The upstream source holds them.

## Timing
- Reset values: `s_ready=0`, `wr_uram=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `done=0`. State is IDLE, all counters are 0.
- Start latency: `start` sampled at edge T → `s_ready=1` and `busy=1` from T+1.
- Write latency: last beat accepted at edge N → `wr_uram=1` during the cycle after N (one cycle), low again after N+1.
- Throughput: BEATS+1 cycles per line with a continuous `s_valid`. The WRITE cycle is a one-cycle bubble with `s_ready=0`.
- `done` coincides with the final `wr_uram`. `busy` drops the cycle after `done`, and a new `start` is accepted from that cycle.
- `wr_data` and `wr_addr` are registered. They hold their last values when `wr_uram=0`; consumers must qualify with `wr_uram`.
- Address wrap: `start_addr=2^URAM_ADDR-1` with 2 lines writes the last address, then address 0.
- Reset mid-job aborts the job. A partially filled line is discarded and never written, and no `done` is issued.

## Structure
- Shared package `uram_pkg` holds:
  - default constants `URAM_WIDTH=3072`, `URAM_ADDR_W=12`, `URAM_BEAT_W=64`;
  - the derived `URAM_BEATS`;
  - the state enum `{IDLE, FILL, WRITE}`, also reused by a future read sequencer.
- Sub-module `uram_line_packer`: the WIDTH-bit line register plus beat index, with ports `clr`, `load`, `beat`, `line`, `last`. The top level keeps the FSM, address counter and remaining-line counter.
- Beat index width is `$clog2(BEATS)`.

## Test plan
- Reset, then `start` with `start_addr=0x010`, `num_lines=1`, and beats k=0..47 carrying `s_data=k`. Required response: one `wr_uram` at `wr_addr=0x010`, `wr_data[k*64+:64]=k` for all k, `done` in the same cycle, `busy=0` the next cycle.
- `num_lines=3`, `start_addr=0xFFF`, continuous `s_valid`. Required response: writes at 0xFFF, 0x000, 0x001, exactly 49 cycles apart, with `s_ready` low only in each WRITE cycle.
- Random `s_valid` gaps (about 50%) over 2 lines. Required response: data is packed in order with no beat lost or duplicated, and `wr_uram` fires only after the 48th accepted beat of each line.
- `num_lines=0`. Required response: `done` one cycle after `start`, no `wr_uram`, `s_ready` stays 0. A second `start` during a running job has no effect on address or count.
- Assert `rst_n` low after 20 beats of a line, then restart with `start_addr=0x005`, `num_lines=1`. Required response: no write from the aborted line, the new line is written at 0x005 containing only the new beats, and all outputs read 0 during reset.
